// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32 decode-stage control unit and its M-unit occupancy tracker.
package rv_ctrl_pkg;

  // Base RV32I major opcodes recognised by the decoder
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Immediate format selector driven to the D-stage immediate generator
  localparam logic [2:0] IMM_ALU  = 3'd0;
  localparam logic [2:0] IMM_U    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_LDJR = 3'd5;
  localparam logic [2:0] IMM_NONE = 3'd6;

  // ALU operand source selects
  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_ZERO = 2'b01;
  localparam logic [1:0] SRCA_RS1  = 2'b11;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALUop layout: {md, funct7[5], funct3}, zero-extended to ALUOP_W
  localparam int ALU_F3_LSB   = 0;
  localparam int ALU_F7B5_BIT = 3;
  localparam int ALU_MD_BIT   = 4;

  // funct7 values accepted on ALUreg
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Control word carried across the ID/EX boundary (ALUop kept separate: its width is a parameter)
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       pc_branch;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] str_ctrl;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode_pipe_md_occupancy.sv
// Tracks how long a multiply/divide op occupies E and stalls the front end until its last cycle.
module md_occupancy
  import rv_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  output logic stall,
  output logic done
);

  localparam logic [3:0] MUL_LAT = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_LAT = 4'(DIV_CYCLES);

  md_state_e  r_state;
  md_state_e  w_state_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic       r_done1;
  logic       w_done1_next;
  logic [3:0] w_lat;

  assign w_lat = is_div ? DIV_LAT : MUL_LAT;

  // State register: counter and single-cycle-op done flag cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MD_IDLE;
      r_cnt   <= 4'd0;
      r_done1 <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_done1 <= w_done1_next;
    end
  end

  // Next state: count down while busy; the last busy cycle behaves like IDLE so a new op can start
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_done1_next = 1'b0;
    if (r_state == MD_BUSY && r_cnt != 4'd0) begin
      w_cnt_next = r_cnt - 4'd1;
    end else if (start) begin
      w_cnt_next   = w_lat - 4'd1;
      w_state_next = (w_lat > 4'd1) ? MD_BUSY : MD_IDLE;
      w_done1_next = (w_lat == 4'd1);
    end else begin
      w_state_next = MD_IDLE;
      w_cnt_next   = 4'd0;
    end
  end

  // Outputs depend only on registered state, so no path exists from the D-stage opcode
  always_comb begin
    stall = (r_state == MD_BUSY) && (r_cnt != 4'd0);
    done  = ((r_state == MD_BUSY) && (r_cnt == 4'd0)) || r_done1;
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// RV32 decode-stage control with optional RV32M, illegal detection and a registered ID/EX control boundary.
module ctrl_decode_pipe
  import rv_ctrl_pkg::*;
#(
  parameter bit ENABLE_M   = 1'b1,
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 8,
  parameter int ALUOP_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               validD,
  input  logic               flushE,
  output logic [2:0]         immSelD,
  output logic               RegWriteE,
  output logic               MemWriteE,
  output logic               MemtoRegE,
  output logic               PCBranchE,
  output logic [1:0]         SrcASelE,
  output logic [1:0]         SrcBSelE,
  output logic [ALUOP_W-1:0] ALUopE,
  output logic [2:0]         strCtrlE,
  output logic               IllegalE,
  output logic               mdStall,
  output logic               mdDoneE
);

  ctrl_t              w_ctrl;
  logic [ALUOP_W-1:0] w_aluop;
  logic [2:0]         w_imm_sel;
  logic               w_legal;
  logic               w_is_md;
  logic               w_load;
  logic               w_start;
  logic               w_stall;
  logic               w_done;
  ctrl_t              r_ctrl;
  logic [ALUOP_W-1:0] r_aluop;

  // D-stage decode of opcode/funct3/funct7 into the control word, ALUop and immediate format
  always_comb begin
    w_ctrl          = CTRL_BUBBLE;
    w_ctrl.src_a    = SRCA_RS1;
    w_ctrl.src_b    = SRCB_RS2;
    w_ctrl.str_ctrl = funct3;
    w_aluop         = '0;
    w_imm_sel       = IMM_NONE;
    w_legal         = 1'b1;
    w_is_md         = 1'b0;
    case (opcode)
      OP_LOAD: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.src_b      = SRCB_IMM;
        w_imm_sel         = IMM_LDJR;
      end
      OP_STORE: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.src_b     = SRCB_IMM;
        w_imm_sel        = IMM_S;
      end
      OP_ALUIMM: begin
        w_ctrl.reg_write             = 1'b1;
        w_ctrl.src_b                 = SRCB_IMM;
        w_aluop[ALU_F3_LSB +: 3]     = funct3;
        w_imm_sel                    = IMM_ALU;
      end
      OP_ALUREG: begin
        w_ctrl.reg_write = 1'b1;
        if (funct7 == F7_BASE || funct7 == F7_ALT) begin
          w_aluop[ALU_F3_LSB +: 3] = funct3;
          w_aluop[ALU_F7B5_BIT]    = funct7[5];
        end else if (ENABLE_M && funct7 == F7_MULDIV) begin
          w_aluop[ALU_F3_LSB +: 3] = funct3;
          w_aluop[ALU_MD_BIT]      = 1'b1;
          w_is_md                  = 1'b1;
        end else begin
          w_legal = 1'b0;
        end
      end
      OP_BRANCH: begin
        w_ctrl.pc_branch         = 1'b1;
        w_aluop[ALU_F3_LSB +: 3] = funct3;
        w_imm_sel                = IMM_B;
      end
      OP_JAL: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.pc_branch = 1'b1;
        w_ctrl.src_a     = SRCA_PC;
        w_ctrl.src_b     = SRCB_FOUR;
        w_imm_sel        = IMM_J;
      end
      OP_JALR: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.pc_branch = 1'b1;
        w_ctrl.src_a     = SRCA_PC;
        w_ctrl.src_b     = SRCB_FOUR;
        w_imm_sel        = IMM_LDJR;
      end
      OP_LUI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.src_a     = SRCA_ZERO;
        w_ctrl.src_b     = SRCB_IMM;
        w_imm_sel        = IMM_U;
      end
      OP_AUIPC: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.src_a     = SRCA_PC;
        w_ctrl.src_b     = SRCB_IMM;
        w_imm_sel        = IMM_U;
      end
      default: w_legal = 1'b0;
    endcase
    // An illegal instruction travels down as an inert word that only flags itself
    if (!w_legal) begin
      w_ctrl         = CTRL_BUBBLE;
      w_ctrl.illegal = 1'b1;
      w_aluop        = '0;
    end
  end

  assign immSelD = w_imm_sel;
  assign w_load  = validD && !flushE;
  assign w_start = !w_stall && w_load && w_is_md;

  md_occupancy #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_md_occupancy (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_start),
    .is_div (funct3[2]),
    .stall  (w_stall),
    .done   (w_done)
  );

  // ID/EX register: hold while the M unit is busy, else bubble or capture the decoded D values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl  <= CTRL_BUBBLE;
      r_aluop <= '0;
    end else if (w_stall) begin
      r_ctrl  <= r_ctrl;
      r_aluop <= r_aluop;
    end else if (w_load) begin
      r_ctrl  <= w_ctrl;
      r_aluop <= w_aluop;
    end else begin
      r_ctrl  <= CTRL_BUBBLE;
      r_aluop <= '0;
    end
  end

  assign RegWriteE = r_ctrl.reg_write;
  assign MemWriteE = r_ctrl.mem_write;
  assign MemtoRegE = r_ctrl.mem_to_reg;
  assign PCBranchE = r_ctrl.pc_branch;
  assign SrcASelE  = r_ctrl.src_a;
  assign SrcBSelE  = r_ctrl.src_b;
  assign strCtrlE  = r_ctrl.str_ctrl;
  assign IllegalE  = r_ctrl.illegal;
  assign ALUopE    = r_aluop;
  assign mdStall   = w_stall;
  assign mdDoneE   = w_done;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe: vector table for decode plus hand sequences for M-unit timing.
module tb_ctrl_decode_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       validD;
  logic       flushE;

  // ENABLE_M=1 instance
  logic [2:0] immSelD;
  logic       RegWriteE, MemWriteE, MemtoRegE, PCBranchE;
  logic [1:0] SrcASelE, SrcBSelE;
  logic [4:0] ALUopE;
  logic [2:0] strCtrlE;
  logic       IllegalE, mdStall, mdDoneE;

  // ENABLE_M=0 instance
  logic [2:0] n_immSelD;
  logic       n_RegWriteE, n_MemWriteE, n_MemtoRegE, n_PCBranchE;
  logic [1:0] n_SrcASelE, n_SrcBSelE;
  logic [4:0] n_ALUopE;
  logic [2:0] n_strCtrlE;
  logic       n_IllegalE, n_mdStall, n_mdDoneE;

  int total = 0;
  int bad   = 0;

  ctrl_decode_pipe #(.ENABLE_M(1'b1), .MUL_CYCLES(1), .DIV_CYCLES(8), .ALUOP_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .validD(validD), .flushE(flushE), .immSelD(immSelD), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE), .PCBranchE(PCBranchE),
    .SrcASelE(SrcASelE), .SrcBSelE(SrcBSelE), .ALUopE(ALUopE), .strCtrlE(strCtrlE),
    .IllegalE(IllegalE), .mdStall(mdStall), .mdDoneE(mdDoneE)
  );

  ctrl_decode_pipe #(.ENABLE_M(1'b0), .MUL_CYCLES(1), .DIV_CYCLES(8), .ALUOP_W(5)) dut_nom (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .validD(validD), .flushE(flushE), .immSelD(n_immSelD), .RegWriteE(n_RegWriteE),
    .MemWriteE(n_MemWriteE), .MemtoRegE(n_MemtoRegE), .PCBranchE(n_PCBranchE),
    .SrcASelE(n_SrcASelE), .SrcBSelE(n_SrcBSelE), .ALUopE(n_ALUopE), .strCtrlE(n_strCtrlE),
    .IllegalE(n_IllegalE), .mdStall(n_mdStall), .mdDoneE(n_mdDoneE)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       vld;
    logic       fl;
    logic [2:0] imm;
    logic       rw;
    logic       mw;
    logic       m2r;
    logic       pcb;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [4:0] alu;
    logic [2:0] str;
    logic       ill;
    logic       done;
    logic       nm_ill;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic v, input logic f);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    validD = v;
    flushE = f;
  endtask

  task automatic check_e(input vec_t e);
    chk("RegWriteE", RegWriteE, e.rw);
    chk("MemWriteE", MemWriteE, e.mw);
    chk("MemtoRegE", MemtoRegE, e.m2r);
    chk("PCBranchE", PCBranchE, e.pcb);
    chk("SrcASelE", SrcASelE, e.sa);
    chk("SrcBSelE", SrcBSelE, e.sb);
    chk("ALUopE", ALUopE, e.alu);
    chk("strCtrlE", strCtrlE, e.str);
    chk("IllegalE", IllegalE, e.ill);
    chk("mdDoneE", mdDoneE, e.done);
    chk("mdStall", mdStall, 1'b0);
  endtask

  initial begin
    int n_stall;
    int cycles;
    logic saw_done;
    logic saw_stall;

    //         op          f3      f7          vld   fl    imm   rw    mw    m2r   pcb   sa     sb     alu       str     ill   done  nm_ill
    vecs[0]  = '{7'b0110011, 3'b000, 7'b0000000, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 5'b00000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{7'b0110011, 3'b000, 7'b0100000, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 5'b01000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{7'b0110011, 3'b010, 7'b0000000, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 5'b00010, 3'b010, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{7'b0110111, 3'b000, 7'b0000000, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 5'b00000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{7'b0010111, 3'b000, 7'b0000000, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 5'b00000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{7'b1101111, 3'b000, 7'b0000000, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 5'b00000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{7'b1100111, 3'b000, 7'b0000000, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 5'b00000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{7'b0000011, 3'b010, 7'b0000000, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 2'b01, 5'b00000, 3'b010, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{7'b0100011, 3'b010, 7'b0000000, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'b01, 5'b00000, 3'b010, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{7'b0010011, 3'b101, 7'b0100000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b01, 5'b00101, 3'b101, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{7'b1100011, 3'b100, 7'b0000000, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 5'b00100, 3'b100, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{7'b0000000, 3'b000, 7'b0000000, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'b00000, 3'b000, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{7'b0110011, 3'b000, 7'b0000010, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'b00000, 3'b000, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{7'b0110011, 3'b000, 7'b0000000, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'b00000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{7'b0110111, 3'b000, 7'b0000000, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'b00000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{7'b0110011, 3'b000, 7'b0000001, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 5'b10000, 3'b000, 1'b0, 1'b1, 1'b1};
    vecs[16] = '{7'b0110011, 3'b011, 7'b0000001, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 5'b10011, 3'b011, 1'b0, 1'b1, 1'b1};
    vecs[17] = '{7'b0110011, 3'b000, 7'b0000000, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 5'b00000, 3'b000, 1'b0, 1'b0, 1'b0};

    // Reset held with a valid ADD at D: E stays a bubble
    drive(7'b0110011, 3'b000, 7'b0000000, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regwrite", RegWriteE, 1'b0);
    chk("rst_srca", SrcASelE, 2'b00);
    chk("rst_stall", mdStall, 1'b0);
    chk("rst_done", mdDoneE, 1'b0);
    rst_n = 1'b1;
    wait_cycle();
    chk("first_add_regwrite", RegWriteE, 1'b1);
    chk("first_add_aluop", ALUopE, 5'b00000);
    chk("first_add_srcb", SrcBSelE, 2'b00);
    $display("reset release: first ADD in E rw=%0b alu=%b", RegWriteE, ALUopE);

    // Asynchronous reset mid-cycle clears E without waiting for an edge
    drive(7'b0110111, 3'b000, 7'b0000000, 1'b1, 1'b0);
    wait_cycle();
    chk("lui_before_async_srca", SrcASelE, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_regwrite", RegWriteE, 1'b0);
    chk("async_rst_srca", SrcASelE, 2'b00);
    chk("async_rst_srcb", SrcBSelE, 2'b00);
    $display("async reset: rw=%0b srca=%b srcb=%b", RegWriteE, SrcASelE, SrcBSelE);
    rst_n = 1'b1;

    // Decode table
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].vld, vecs[i].fl);
      #1;
      chk("immSelD", immSelD, vecs[i].imm);
      wait_cycle();
      check_e(vecs[i]);
      chk("nom_IllegalE", n_IllegalE, vecs[i].nm_ill);
      chk("nom_RegWriteE", n_RegWriteE, vecs[i].nm_ill ? 1'b0 : vecs[i].rw);
      $display("vec %0d op=%b f3=%b f7=%b -> rw=%0b alu=%b ill=%0b done=%0b", i, vecs[i].op,
               vecs[i].f3, vecs[i].f7, RegWriteE, ALUopE, IllegalE, mdDoneE);
    end

    // DIV occupies E for 8 cycles, stalling for the first 7; SUB follows directly
    drive(7'b0110011, 3'b100, 7'b0000001, 1'b1, 1'b0);
    wait_cycle();
    n_stall = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) wait_cycle();
      chk("div_held_aluop", ALUopE, 5'b10100);
      chk("div_done", mdDoneE, (k == 8));
      if (mdStall) n_stall++;
      if (k == 1) drive(7'b0110011, 3'b000, 7'b0100000, 1'b1, 1'b0);
    end
    chk("div_stall_cycles", n_stall, 7);
    wait_cycle();
    chk("sub_after_div_aluop", ALUopE, 5'b01000);
    chk("sub_after_div_regwrite", RegWriteE, 1'b1);
    chk("sub_after_div_done", mdDoneE, 1'b0);
    chk("sub_after_div_stall", mdStall, 1'b0);
    $display("DIV: stall cycles=%0d, then SUB alu=%b", n_stall, ALUopE);

    // MUL (1 cycle) then DIVU back-to-back with no bubble
    drive(7'b0110011, 3'b000, 7'b0000001, 1'b1, 1'b0);
    wait_cycle();
    chk("mul_aluop", ALUopE, 5'b10000);
    chk("mul_done", mdDoneE, 1'b1);
    chk("mul_stall", mdStall, 1'b0);
    drive(7'b0110011, 3'b101, 7'b0000001, 1'b1, 1'b0);
    wait_cycle();
    chk("divu_b2b_aluop", ALUopE, 5'b10101);
    chk("divu_b2b_stall", mdStall, 1'b1);
    drive(7'b0110011, 3'b000, 7'b0000000, 1'b1, 1'b0);
    cycles = 1;
    while (mdStall && cycles < 20) begin
      wait_cycle();
      cycles++;
    end
    chk("divu_last_cycle_index", cycles, 8);
    chk("divu_done", mdDoneE, 1'b1);
    chk("divu_held_aluop", ALUopE, 5'b10101);
    wait_cycle();
    chk("add_after_divu_aluop", ALUopE, 5'b00000);
    chk("add_after_divu_regwrite", RegWriteE, 1'b1);
    chk("add_after_divu_done", mdDoneE, 1'b0);
    $display("MUL->DIVU: DIVU last cycle=%0d, then ADD rw=%0b", cycles, RegWriteE);

    // flushE during BUSY is ignored; reset in BUSY cycle 4 aborts with no done pulse
    drive(7'b0110011, 3'b100, 7'b0000001, 1'b1, 1'b0);
    wait_cycle();
    drive(7'b0110011, 3'b000, 7'b0000000, 1'b1, 1'b0);
    wait_cycle();
    wait_cycle();
    flushE = 1'b1;
    wait_cycle();
    chk("flush_busy_aluop", ALUopE, 5'b10100);
    chk("flush_busy_regwrite", RegWriteE, 1'b1);
    chk("flush_busy_stall", mdStall, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("busy_rst_aluop", ALUopE, 5'b00000);
    chk("busy_rst_regwrite", RegWriteE, 1'b0);
    chk("busy_rst_stall", mdStall, 1'b0);
    chk("busy_rst_done", mdDoneE, 1'b0);
    flushE = 1'b0;
    validD = 1'b0;
    rst_n = 1'b1;
    saw_done = 1'b0;
    saw_stall = 1'b0;
    for (int k = 0; k < 12; k++) begin
      wait_cycle();
      if (mdDoneE) saw_done = 1'b1;
      if (mdStall) saw_stall = 1'b1;
    end
    chk("post_abort_no_done", saw_done, 1'b0);
    chk("post_abort_no_stall", saw_stall, 1'b0);
    chk("post_abort_bubble", RegWriteE, 1'b0);
    $display("DIV abort: done seen=%0b stall seen=%0b", saw_done, saw_stall);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_pipe.md
Name: ctrl_decode_pipe

Overview:
Parametrised successor of the decode-stage control unit for the five-stage RV32 core. It decodes opcode/funct3/funct7 into control signals, adds an optional RV32M extension and illegal-instruction detection, and registers all control into the ID/EX boundary with bubble and flush support. A multiply/divide occupancy FSM stalls the front end for the configured number of M-unit execute cycles.

Parameters:
ENABLE_M, 1, when 1 RV32M ops are legal; when 0, funct7=0000001 on ALUreg is illegal
MUL_CYCLES, 1, E-stage occupancy of MUL/MULH/MULHSU/MULHU (1..15)
DIV_CYCLES, 8, E-stage occupancy of DIV/DIVU/REM/REMU (1..15)
ALUOP_W, 5, ALU op width {md, funct7[5], funct3}; must be >=5

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  instruction[6:0] in D
funct3  in  3  instruction[14:12] in D
funct7  in  7  instruction[31:25] in D
validD  in  1  D holds a real instruction
flushE  in  1  hazard unit: load a bubble into E
immSelD  out  3  immediate format for D-stage immediate generation (combinational)
RegWriteE, MemWriteE, MemtoRegE, PCBranchE  out  1 each  registered control
SrcASelE  out  2  00 PC, 01 zero, 11 rs1
SrcBSelE  out  2  00 rs2, 01 imm, 10 const 4
ALUopE  out  ALUOP_W  ALU/M-unit operation
strCtrlE  out  3  funct3 for load/store width
IllegalE  out  1  E holds an illegal instruction
mdStall  out  1  freeze PC, F/D and D/E registers
mdDoneE  out  1  one-cycle pulse in last M-op execute cycle

Behaviour:
- Decode (combinational, D):
  - RegWrite = Load|ALUreg|ALUimm|LUI|AUIPC|JAL|JALR.
  - MemWrite = Store. MemtoReg = Load. PCBranch = Branch|JAL|JALR.
  - SrcA: PC for JAL/JALR/AUIPC, zero for LUI, rs1 otherwise.
  - SrcB: imm for Load/Store/ALUimm/LUI/AUIPC, 4 for JAL/JALR, rs2 otherwise.
- ALUop:
  - ALUimm/Branch: {0,0,funct3}.
  - ALUreg, funct7=0000000/0100000: {0,funct7[5],funct3}.
  - ALUreg, funct7=0000001 with ENABLE_M: {1,0,funct3}.
  - All else: 0.
- immSelD: 0 ALUimm, 1 LUI/AUIPC, 2 Store, 3 Branch, 4 JAL, 5 Load/JALR, 6 other.
- Illegal: an opcode outside the nine defined, or ALUreg with any other funct7. Illegal instructions load into E with all write/branch enables 0 and IllegalE=1.
- E register update at each rising edge, priority order:
  1. rst_n low: asynchronously clear all registered outputs to 0 (bubble), FSM to IDLE, counter to 0, mdStall=0, mdDoneE=0.
  2. FSM BUSY: hold E contents. flushE is ignored; the hazard unit must hold flushE until mdStall falls.
  3. flushE or !validD: load a bubble (all 0).
  4. Otherwise load the decoded D values.
- M-op FSM, states IDLE and BUSY, 4-bit counter cnt:
  - IDLE: when an M op is loaded into E, cnt <= LAT-1, where LAT = DIV_CYCLES if funct3[2], else MUL_CYCLES. Go to BUSY if LAT>1; otherwise stay IDLE and pulse mdDoneE in E's single cycle.
  - BUSY: cnt decrements each cycle. mdStall = (state==BUSY) and cnt!=0. When cnt==0: mdDoneE=1, state <= IDLE, and E accepts D at that edge.
  - mdStall is a registered-state function with no combinational path from opcode.
  - Total E occupancy of an M op is exactly LAT cycles.
- Back-to-back M ops: the second loads on the edge that ends the first; no idle cycle between them.
- Reset mid-BUSY: abort immediately. The instruction in E is discarded as a bubble, and no mdDoneE is produced.

Decomposition:
- Package rv_ctrl_pkg holds:
  - Opcode constants (Load, Store, ALUimm, ALUreg, Branch, JAL, JALR, LUI, AUIPC).
  - immSel, SrcASel and SrcBSel encodings.
  - ALUop field positions and the MULDIV funct7 constant.
- Sub-module md_occupancy holds the FSM and counter, with inputs start, is_div and outputs stall, done.
- Decode logic stays combinational in the top module.

Test Plan:
- Reset: hold rst_n=0 mid-cycle with validD=1 ADD -> all E outputs 0 and mdStall=0 immediately (asynchronous); after release, the first ADD appears at E next edge with RegWriteE=1, ALUopE=5'b00000, SrcB=00.
- Decode sweep: LUI -> SrcA=01, SrcB=01, immSelD=1, RegWriteE=1. JAL -> SrcA=00, SrcB=10, PCBranchE=1, immSelD=4. SW -> MemWriteE=1, RegWriteE=0, strCtrlE=010, immSelD=2.
- DIV with DIV_CYCLES=8 -> mdStall high 7 cycles, mdDoneE pulses in cycle 8, E held throughout. Following SUB enters E the next edge with ALUopE=5'b01000.
- MUL with MUL_CYCLES=1 -> mdStall never asserts; mdDoneE pulses in the single E cycle. MUL then DIVU back-to-back -> no bubble between them.
- ENABLE_M=0 with MUL, and opcode 0000000 -> IllegalE=1, RegWriteE=0, MemWriteE=0. flushE=1 on a valid ADD -> bubble in E.
- flushE asserted in BUSY cycle 3 of a DIV -> E unchanged. Reset pulse in BUSY cycle 4 -> IDLE, bubble, and no mdDoneE.
